fp_multiplier_rne: RTL and testbench

//  Parametrised IEEE-754 binary multiplier (any EXP_W/MAN_W; default binary32), iterative mantissa datapath.

---
 rtl/fp_pkg.sv | 33 +++
 rtl/fp_multiplier_rne_if.sv | 32 +++
 rtl/mant_shift_add_mul.sv | 51 +++++
 rtl/fp_multiplier_rne.sv | 201 ++++++++++++++++++++
 tb/tb_fp_multiplier_rne.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the FP multiplier: FSM encoding, operand classes and
// width-dependent constants (bias, max exponent) expressed as helper functions.
package fp_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_MUL,
    ST_NORM,
    ST_ROUND
  } fsm_state_t;

  typedef enum logic [2:0] {
    CL_ZERO,
    CL_SUB,
    CL_NORM,
    CL_INF,
    CL_QNAN,
    CL_SNAN
  } op_class_t;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int exp_max_of(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fp_multiplier_rne_if.sv
// Operation handshake bundle between a requester (master) and the multiplier (slave).
interface fp_multiplier_rne_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = EXP_W + MAN_W + 1;

  // start is taken only while busy==0; a/b are sampled on that edge only.
  // busy rises the cycle after accept and stays high through the done cycle;
  // done is a one-cycle pulse and result/flags hold until the next accept.
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         busy;
  logic         done;
  logic         overflow;
  logic         underflow;
  logic         inexact;
  logic         invalid;

  modport master (
    output start, a, b,
    input  result, busy, done, overflow, underflow, inexact, invalid
  );

  modport slave (
    input  start, a, b,
    output result, busy, done, overflow, underflow, inexact, invalid
  );

endinterface

// File: rtl/mant_shift_add_mul.sv
// Iterative unsigned W x W radix-2 shift-add multiplier: one partial product
// per cycle, done pulses the cycle the last partial product has been added.
module mant_shift_add_mul #(
  parameter int W = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           done
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      run     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        product <= '0;
        mcand   <= {{W{1'b0}}, a};
        mplier  <= b;
        cnt     <= '0;
        run     <= 1'b1;
      end else if (run) begin
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == CW'(W - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fp_multiplier_rne.sv
// IEEE-754 multiplier with round-to-nearest-even, subnormal support and status
// flags; fixed latency of MAN_W+4 cycles from accept to done for every operand.
module fp_multiplier_rne
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_multiplier_rne_if.slave   bus,
  output fsm_state_t           dbg_state
);

  localparam int W       = EXP_W + MAN_W + 1;
  localparam int P       = MAN_W + 1;
  localparam int EW2     = EXP_W + 2;
  localparam int LW      = $clog2(2 * P + 1);
  localparam int BIAS    = bias_of(EXP_W);
  localparam int EXP_MAX = exp_max_of(EXP_W);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic op_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '1) return (f == '0) ? CL_INF : (f[MAN_W-1] ? CL_QNAN : CL_SNAN);
    if (e == '0) return (f == '0) ? CL_ZERO : CL_SUB;
    return CL_NORM;
  endfunction

  fsm_state_t state, state_nxt;

  logic [W-1:0]           a_q, b_q;
  logic                   sign_q, spec_q, spec_inv_q;
  logic [W-1:0]           spec_res_q;
  logic signed [EW2-1:0]  e_q, en_q;
  logic [P-1:0]           kept_q;
  logic                   g_q, s_q;
  logic [W-1:0]           result_q;
  logic                   ovf_q, unf_q, inx_q, inv_q;

  // ---------------- FSM ----------------
  logic                   mul_done;
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.start) state_nxt = ST_UNPACK;
      ST_UNPACK: state_nxt = ST_MUL;
      ST_MUL:    if (mul_done) state_nxt = ST_NORM;
      ST_NORM:   state_nxt = ST_ROUND;
      ST_ROUND:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- Unpack / special classification ----------------
  logic [EXP_W-1:0]      ea_f, eb_f;
  op_class_t             cls_a, cls_b;
  logic [P-1:0]          mant_a, mant_b;
  logic signed [EW2-1:0] e_unp;
  logic                  sign_u, nan_u, inf_u, zero_u, spec_inv_u;
  logic [W-1:0]          spec_res_u;

  always_comb begin
    ea_f   = a_q[W-2 -: EXP_W];
    eb_f   = b_q[W-2 -: EXP_W];
    cls_a  = classify(ea_f, a_q[MAN_W-1:0]);
    cls_b  = classify(eb_f, b_q[MAN_W-1:0]);
    mant_a = {(ea_f != '0), a_q[MAN_W-1:0]};
    mant_b = {(eb_f != '0), b_q[MAN_W-1:0]};
    // Subnormals use effective exponent 1; +1 places the binary point at bit 2P-2.
    e_unp  = EW2'((ea_f == '0) ? EXP_W'(1) : ea_f) + EW2'((eb_f == '0) ? EXP_W'(1) : eb_f)
             - EW2'(BIAS) + EW2'(1);
    sign_u = a_q[W-1] ^ b_q[W-1];
    nan_u  = (cls_a == CL_QNAN) || (cls_a == CL_SNAN) || (cls_b == CL_QNAN) || (cls_b == CL_SNAN);
    inf_u  = (cls_a == CL_INF) || (cls_b == CL_INF);
    zero_u = (cls_a == CL_ZERO) || (cls_b == CL_ZERO);
    spec_inv_u = (cls_a == CL_SNAN) || (cls_b == CL_SNAN) || (inf_u && zero_u);
    if (nan_u || (inf_u && zero_u)) spec_res_u = QNAN;
    else if (inf_u)                 spec_res_u = {sign_u, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else                            spec_res_u = {sign_u, {(W-1){1'b0}}};
  end

  // ---------------- Mantissa multiplier ----------------
  logic [2*P-1:0] mul_prod;

  mant_shift_add_mul #(.W(P)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (state == ST_UNPACK),
    .a       (mant_a),
    .b       (mant_b),
    .product (mul_prod),
    .done    (mul_done)
  );

  // ---------------- Normalise (LZC, left shift, denormalising right shift) ----------------
  logic [LW-1:0]         lzc;
  logic [2*P-1:0]        shl, man_n;
  logic signed [EW2-1:0] e1, e_n;
  logic [EW2-1:0]        rsh;
  logic                  stk_n;

  always_comb begin
    lzc = LW'(2 * P);
    for (int i = 0; i < 2 * P; i++) if (mul_prod[i]) lzc = LW'(2 * P - 1 - i);
    shl   = mul_prod << lzc;
    e1    = e_q - EW2'(lzc);
    e_n   = e1;
    man_n = shl;
    rsh   = '0;
    stk_n = 1'b0;
    if (e1 < 1) begin
      rsh = EW2'(1) - e1;
      e_n = '0;
      if (rsh >= EW2'(2 * P)) begin
        man_n = '0;
        stk_n = |shl;
      end else begin
        man_n = shl >> rsh;
        stk_n = |(shl & ~({(2*P){1'b1}} << rsh));
      end
    end
  end

  // ---------------- Round to nearest even ----------------
  logic                  inc_r, ovf_r;
  logic [P:0]            sum_r;
  logic signed [EW2-1:0] e_r;

  always_comb begin
    inc_r = g_q & (s_q | kept_q[0]);
    sum_r = {1'b0, kept_q} + {{P{1'b0}}, inc_r};
    e_r   = en_q + EW2'(sum_r[P]);
    // A subnormal that rounds up into the hidden-bit position becomes min normal.
    if ((en_q == '0) && sum_r[P-1]) e_r = EW2'(1);
    ovf_r = (e_r >= EW2'(EXP_MAX));
  end

  // ---------------- Registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_inv_q <= 1'b0;
      spec_res_q <= '0;
      e_q        <= '0;
      en_q       <= '0;
      kept_q     <= '0;
      g_q        <= 1'b0;
      s_q        <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      inx_q      <= 1'b0;
      inv_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && bus.start) begin
        a_q <= bus.a;
        b_q <= bus.b;
      end
      if (state == ST_UNPACK) begin
        sign_q     <= sign_u;
        e_q        <= e_unp;
        spec_q     <= nan_u | inf_u | zero_u;
        spec_inv_q <= spec_inv_u;
        spec_res_q <= spec_res_u;
      end
      if (state == ST_MUL && mul_done) begin
        kept_q <= man_n[2*P-1:P];
        g_q    <= man_n[P-1];
        s_q    <= (|man_n[P-2:0]) | stk_n;
        en_q   <= e_n;
      end
      if (state == ST_NORM) begin
        if (spec_q) begin
          result_q <= spec_res_q;
          {ovf_q, unf_q, inx_q, inv_q} <= {3'b000, spec_inv_q};
        end else if (ovf_r) begin
          result_q <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          {ovf_q, unf_q, inx_q, inv_q} <= 4'b1010;
        end else begin
          result_q <= {sign_q, e_r[EXP_W-1:0], sum_r[P-2:0]};
          {ovf_q, unf_q, inx_q, inv_q} <= {1'b0, (en_q == '0) & (g_q | s_q), g_q | s_q, 1'b0};
        end
      end
    end
  end

  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.inexact   = inx_q;
  assign bus.invalid   = inv_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_ROUND);
  assign dbg_state     = state;

endmodule

// File: tb/tb_fp_multiplier_rne.sv
// Directed bench for fp_multiplier_rne (binary32): hand-computed products,
// flags, fixed latency, busy/start interplay and mid-operation reset.
module tb_fp_multiplier_rne;
  import fp_pkg::*;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int LAT   = MAN_W + 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  fsm_state_t dbg_state;
  logic [3:0] flags;
  int         total = 0;
  int         bad   = 0;

  fp_multiplier_rne_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_multiplier_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  assign flags = {bus.overflow, bus.underflow, bus.inexact, bus.invalid};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // flags order: {overflow, underflow, inexact, invalid}
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [3:0] exp_fl, input int poke);
    int n;
    int dones;
    bit seen;
    drive_start(a, b);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) seen = 1'b1;
      else if (poke != 0 && n == poke) begin
        bus.a     = 32'h3F800000;
        bus.b     = 32'h3F800000;
        bus.start = 1'b1;
      end else bus.start = 1'b0;
    end
    check({tag, "_latency"}, 64'(n), 64'(LAT));
    check({tag, "_result"}, 64'(bus.result), 64'(exp_res));
    check({tag, "_flags"}, 64'(flags), 64'(exp_fl));
    check({tag, "_busy_in_done"}, 64'(bus.busy), 64'd1);
    if (poke != 0) begin
      bus.a     = 32'h3F800000;
      bus.b     = 32'h3F800000;
      bus.start = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    if (poke != 0) begin
      dones = 0;
      repeat (35) begin
        @(posedge clk);
        #1;
        if (bus.done) dones++;
      end
      check({tag, "_extra_done"}, 64'(dones), 64'd0);
      check({tag, "_result_held"}, 64'(bus.result), 64'(exp_res));
    end
  endtask

  initial begin
    int dones;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", 64'(bus.result), 64'd0);
    check("reset_flags", 64'(flags), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    rst = 1'b1;

    run_op("mul_3x2",      32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000, 0);
    run_op("tie_even_dn",  32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0010, 0);
    run_op("tie_even_up",  32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0010, 0);
    run_op("overflow",     32'h7F000000, 32'h40000000, 32'h7F800000, 4'b1010, 0);
    run_op("underflow",    32'h00000001, 32'h3F000000, 32'h00000000, 4'b0110, 0);
    run_op("inf_x_zero",   32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b0001, 0);
    run_op("neg_inf",      32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 0);
    run_op("exact_sub",    32'h00800000, 32'h3F000000, 32'h00400000, 4'b0000, 0);
    run_op("sub_to_norm",  32'h007FFFFF, 32'h3F800001, 32'h00800000, 4'b0110, 0);
    run_op("snan",         32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b0001, 0);
    run_op("qnan_x_inf",   32'h7FC00000, 32'hFF800000, 32'h7FC00000, 4'b0000, 0);
    run_op("neg_zero",     32'h80000000, 32'h40400000, 32'h80000000, 4'b0000, 0);
    run_op("busy_ignore",  32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000, 5);

    // Abort an operation with reset ten cycles after accept.
    drive_start(32'h40400000, 32'h40400000);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_result", 64'(bus.result), 64'd0);
    check("abort_flags", 64'(flags), 64'd0);
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    dones = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    run_op("after_abort",  32'hC0400000, 32'h40000000, 32'hC0C00000, 4'b0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
